// File: rtl/ar9331_link_pkg.sv
// Shared definitions for the AR9331 <-> FPGA parallel byte link.
// The transmitter side reuses the timing defaults and idle levels.
package ar9331_link_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LEN,
      SETTLE_L,
      WAIT_B,
      SETTLE_B,
      HOLD,
      DONE,
      WAIT_END
   } link_state_e;

   // Idle levels of the toggle lines and the frame line after reset
   localparam logic ACK_IDLE   = 1'b0;
   localparam logic STRB_IDLE  = 1'b0;
   localparam logic FRAME_IDLE = 1'b0;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_SETTLE_CYC  = 2;
   localparam int DEF_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/link_sync_edge.sv
// N-stage synchronizer for one asynchronous link line, with rise/fall
// detection on the synchronized level. STAGES must be at least 2.
module link_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // shift the async line through the chain; prev holds the last synced level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], async_in};
         prev  <= chain[STAGES-1];
      end
   end

   assign sync = chain[STAGES-1];
   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule

// File: rtl/ar9331_rx_link.sv
// Responder end of the AR9331 parallel byte link. Each strobe toggle
// announces a byte on link_data; the byte is sampled after a settle delay,
// acknowledged by toggling link_ack and handed to a valid/ready stream.
// Frames are a length byte followed by that many payload bytes.
// Build option RX_CHECKSUM_EN: a trailing mod-256 checksum byte over the
// length and payload is expected, acked, checked and never output.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no frame, waiting for link_frame rising
// WAIT_LEN | frame open, waiting for the strobe of the length byte
// SETTLE_L | letting link_data settle, then capture length and ack
// WAIT_B   | waiting for the next payload (or checksum) strobe
// SETTLE_B | letting link_data settle before the byte is taken
// HOLD     | byte ready; load and ack once the holding register frees up
// DONE     | all bytes acked, waiting for the holding register to drain
// WAIT_END | frame complete, waiting for link_frame to drop
module ar9331_rx_link
   import ar9331_link_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       link_frame,
   input  logic       link_strb,
   input  logic [7:0] link_data,
   output logic       link_ack,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_first,
   output logic       m_last,
   output logic       frame_done,
   output logic       frame_err,
   output logic       busy
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   // the length settle runs one extra cycle so length and payload acks
   // share the same pin-to-ack latency
   localparam logic [SW-1:0] SETTLE_LEN = SW'(SETTLE_CYC);
   localparam logic [SW-1:0] SETTLE_PAY = SW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT_CYC - 1);

   link_state_e   state;
   logic [SW-1:0] settle_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [7:0]    rem;
   logic          first_pend;
`ifdef RX_CHECKSUM_EN
   logic [7:0]    cks;
   logic          cks_bad;
`endif

   logic frame_sync, frame_rise, frame_fall;
   logic strb_sync_unused, strb_rise, strb_fall;
   logic strb_edge, wait_state, tmo_run, abort_fall, abort_tmo, hold_free;

   link_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(FRAME_IDLE)) u_sync_frame (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (link_frame),
      .sync     (frame_sync),
      .rise     (frame_rise),
      .fall     (frame_fall)
   );

   link_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(STRB_IDLE)) u_sync_strb (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (link_strb),
      .sync     (strb_sync_unused),
      .rise     (strb_rise),
      .fall     (strb_fall)
   );

   // the edge detector's history register runs every cycle, so edges seen
   // while idle, settling or holding are consumed and never taken later
   assign strb_edge  = strb_rise | strb_fall;
   assign wait_state = (state == WAIT_LEN) || (state == WAIT_B);
   assign tmo_run    = wait_state || (state == SETTLE_L) || (state == SETTLE_B);
   assign abort_fall = frame_fall && (state != IDLE) && (state != DONE) && (state != WAIT_END);
   assign abort_tmo  = wait_state && (tmo_cnt == '0) && !strb_edge;
   assign hold_free  = !m_valid || m_ready;

   // link sequencer, holding register and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         settle_cnt <= '0;
         tmo_cnt    <= '0;
         rem        <= 8'h00;
         first_pend <= 1'b0;
         link_ack   <= ACK_IDLE;
         m_data     <= 8'h00;
         m_valid    <= 1'b0;
         m_first    <= 1'b0;
         m_last     <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
`ifdef RX_CHECKSUM_EN
         cks        <= 8'h00;
         cks_bad    <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (m_valid && m_ready)
            m_valid <= 1'b0;
         if (tmo_run && (tmo_cnt != '0))
            tmo_cnt <= tmo_cnt - 1'b1;

         if (abort_fall || abort_tmo) begin
            // a byte still held is delivered, but never flagged as last
            frame_err <= 1'b1;
            m_last    <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  rem        <= 8'h00;
                  tmo_cnt    <= TMO_LOAD;
                  first_pend <= 1'b0;
`ifdef RX_CHECKSUM_EN
                  cks_bad    <= 1'b0;
`endif
                  if (frame_rise) begin
                     state <= WAIT_LEN;
                     busy  <= 1'b1;
                  end
               end
               WAIT_LEN: begin
                  if (strb_edge) begin
                     settle_cnt <= SETTLE_LEN;
                     tmo_cnt    <= TMO_LOAD;
                     state      <= SETTLE_L;
                  end
               end
               SETTLE_L: begin
                  if (settle_cnt == '0) begin
                     rem        <= link_data;
                     first_pend <= 1'b1;
                     link_ack   <= ~link_ack;
`ifdef RX_CHECKSUM_EN
                     cks        <= link_data;
                     state      <= WAIT_B;
`else
                     state      <= (link_data == 8'h00) ? DONE : WAIT_B;
`endif
                  end else begin
                     settle_cnt <= settle_cnt - 1'b1;
                  end
               end
               WAIT_B: begin
                  if (strb_edge) begin
                     settle_cnt <= SETTLE_PAY;
                     tmo_cnt    <= TMO_LOAD;
                     state      <= SETTLE_B;
                  end
               end
               SETTLE_B: begin
                  if (settle_cnt == '0) begin
`ifdef RX_CHECKSUM_EN
                     // rem already zero means this strobe carried the checksum
                     if (rem == 8'h00) begin
                        cks_bad  <= (link_data != cks);
                        link_ack <= ~link_ack;
                        state    <= DONE;
                     end else begin
                        state <= HOLD;
                     end
`else
                     state <= HOLD;
`endif
                  end else begin
                     settle_cnt <= settle_cnt - 1'b1;
                  end
               end
               HOLD: begin
                  // ack is withheld while the register is full: that is the
                  // backpressure path to the AR9331
                  if (hold_free) begin
                     m_data     <= link_data;
                     m_valid    <= 1'b1;
                     m_first    <= first_pend;
                     m_last     <= (rem == 8'd1);
                     first_pend <= 1'b0;
                     link_ack   <= ~link_ack;
                     rem        <= rem - 8'd1;
`ifdef RX_CHECKSUM_EN
                     cks        <= cks + link_data;
                     state      <= WAIT_B;
`else
                     state      <= (rem == 8'd1) ? DONE : WAIT_B;
`endif
                  end
               end
               DONE: begin
                  if (!m_valid) begin
`ifdef RX_CHECKSUM_EN
                     frame_done <= !cks_bad;
                     frame_err  <= cks_bad;
`else
                     frame_done <= 1'b1;
`endif
                     state <= WAIT_END;
                  end
               end
               WAIT_END: begin
                  if (!frame_sync) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ar9331_rx_link.sv
// Scoreboard bench for ar9331_rx_link: an AR9331-side sender drives frames,
// expected stream bytes and frame events are queued from the frame contents,
// and a monitor compares whatever the DUT presents.
module tb_ar9331_rx_link;

   localparam int T_CYC     = 4096;
   localparam int ACK_BOUND = 400;
`ifdef RX_CHECKSUM_EN
   localparam bit CK_ON = 1'b1;
`else
   localparam bit CK_ON = 1'b0;
`endif
   localparam logic [1:0] EV_DONE = 2'b01;
   localparam logic [1:0] EV_ERR  = 2'b10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       link_frame = 1'b0;
   logic       link_strb = 1'b0;
   logic [7:0] link_data = 8'h00;
   logic       link_ack;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b1;
   logic       m_first;
   logic       m_last;
   logic       frame_done;
   logic       frame_err;
   logic       busy;

   int vectors = 0;
   int errs = 0;
   int cyc = 0;
   int ack_cnt = 0;
   logic ack_prev = 1'b0;
   int rdy_mode = 0;          // 0: ready high, 1: random, 2: held by test
   int strb_cyc = 0;
   int err_cyc = 0;
   bit err_seen = 1'b0;

   logic [9:0] exp_q[$];      // {data, first, last}
   logic [1:0] ev_q[$];       // {err, done}
   logic [7:0] pl[$];

   ar9331_rx_link dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .link_frame (link_frame),
      .link_strb  (link_strb),
      .link_data  (link_data),
      .link_ack   (link_ack),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_first    (m_first),
      .m_last     (m_last),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #700000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ready throttling
   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) m_ready = 1'b1;
      else if (rdy_mode == 1) m_ready = 1'($urandom_range(0, 1));
   end

   // monitor: ack toggles, stream bytes and frame events
   initial forever begin
      @(negedge clk);
      if (link_ack !== ack_prev) ack_cnt++;
      ack_prev = link_ack;
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0)
            check("unexpected_byte", 32'({m_data, m_first, m_last}), 32'h3ff);
         else
            check("stream_byte", 32'({m_data, m_first, m_last}), 32'(exp_q.pop_front()));
      end
      if (frame_done || frame_err) begin
         if (frame_err) begin
            err_seen = 1'b1;
            err_cyc  = cyc;
         end
         if (ev_q.size() == 0)
            check("unexpected_event", 32'({frame_err, frame_done}), 32'h0);
         else
            check("frame_event", 32'({frame_err, frame_done}), 32'(ev_q.pop_front()));
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int  start;
      bit  ok;
      link_data = b;
      cyc_wait(2);
      start     = ack_cnt;
      link_strb = ~link_strb;
      strb_cyc  = cyc;
      ok = 1'b0;
      for (int i = 0; i < ACK_BOUND; i++) begin
         @(posedge clk);
         #1;
         if (ack_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
      check("ack_wait", 32'(ok), 32'd1);
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while ((exp_q.size() != 0 || ev_q.size() != 0) && i < 3000) begin
         @(posedge clk);
         #1;
         i++;
      end
      check("drain", 32'(exp_q.size() + ev_q.size()), 32'd0);
      exp_q.delete();
      ev_q.delete();
   endtask

   // one frame from pl; n_send < pl.size() drops link_frame early
   task automatic run_frame(input int n_send, input bit bad_ck);
      int         len, a0, ns;
      bit         complete;
      logic [7:0] sum;
      len      = pl.size();
      complete = (n_send >= len);
      ns       = complete ? len : n_send;
      sum      = 8'(len);
      for (int i = 0; i < len; i++) sum = sum + pl[i];
      for (int i = 0; i < ns; i++)
         exp_q.push_back({pl[i], 1'(i == 0), 1'(complete && (i == len - 1))});
      if (complete && !(CK_ON && bad_ck)) ev_q.push_back(EV_DONE);
      else ev_q.push_back(EV_ERR);

      a0 = ack_cnt;
      link_frame = 1'b1;
      cyc_wait(4);
      send_byte(8'(len));
      for (int i = 0; i < ns; i++) send_byte(pl[i]);
      if (CK_ON && complete) send_byte(bad_ck ? sum + 8'd1 : sum);
      if (complete) begin
         wait_drain();
         check("busy_before_drop", 32'(busy), 32'd1);
      end
      cyc_wait(2);
      link_frame = 1'b0;
      cyc_wait(10);
      wait_drain();
      check("busy_after_drop", 32'(busy), 32'd0);
      check("ack_toggles", 32'(ack_cnt - a0), 32'(1 + ns + ((CK_ON && complete) ? 1 : 0)));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_link_ack"},   32'(link_ack),   32'd0);
      check({tag, "_m_valid"},    32'(m_valid),    32'd0);
      check({tag, "_m_data"},     32'(m_data),     32'd0);
      check({tag, "_m_first"},    32'(m_first),    32'd0);
      check({tag, "_m_last"},     32'(m_last),     32'd0);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      check({tag, "_frame_err"},  32'(frame_err),  32'd0);
      check({tag, "_busy"},       32'(busy),       32'd0);
   endtask

   initial begin
      int a_s, len, ns;

      #23;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      cyc_wait(5);

      // basic frame, ready high
      rdy_mode = 0;
      pl.delete(); pl.push_back(8'hA1); pl.push_back(8'hB2); pl.push_back(8'hC3);
      run_frame(3, 1'b0);

      // same frame with the stream stalled after the first byte
      rdy_mode = 2;
      m_ready  = 1'b0;
      a_s      = ack_cnt;
      fork
         run_frame(3, 1'b0);
         begin
            int i;
            i = 0;
            while ((ack_cnt - a_s) < 2 && i < 500) begin
               @(posedge clk);
               #1;
               i++;
            end
            cyc_wait(50);
            check("stall_ack_hold", 32'(ack_cnt - a_s), 32'd2);
            m_ready = 1'b1;
         end
      join
      rdy_mode = 0;

      // empty frame
      pl.delete();
      run_frame(0, 1'b0);

      // frame dropped after 2 of 5 bytes, then a clean single-byte frame
      rdy_mode = 1;
      pl.delete();
      pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h03);
      pl.push_back(8'h04); pl.push_back(8'h05);
      run_frame(2, 1'b0);
      pl.delete(); pl.push_back(8'h5A);
      run_frame(1, 1'b0);

`ifdef RX_CHECKSUM_EN
      pl.delete(); pl.push_back(8'h10); pl.push_back(8'h20);
      run_frame(2, 1'b0);
      run_frame(2, 1'b1);
`endif

      // randomized frames with random throttling and occasional drops
      for (int f = 0; f < 24; f++) begin
         len = int'($urandom_range(0, 8));
         pl.delete();
         for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
         ns = len;
         if (len > 0 && $urandom_range(0, 3) == 0) ns = int'($urandom_range(0, len - 1));
         run_frame(ns, 1'($urandom_range(0, 1)));
      end

      // strobe stops in WAIT_B: timeout abort
      rdy_mode = 0;
      cyc_wait(2);
      exp_q.push_back({8'h11, 1'b1, 1'b0});
      ev_q.push_back(EV_ERR);
      err_seen   = 1'b0;
      link_frame = 1'b1;
      cyc_wait(4);
      send_byte(8'd3);
      send_byte(8'h11);
      for (int i = 0; i < T_CYC + 50; i++) begin
         @(posedge clk);
         #1;
         if (err_seen) break;
      end
      check("timeout_seen", 32'(err_seen), 32'd1);
      check("timeout_not_early", 32'((err_cyc - strb_cyc) >= T_CYC), 32'd1);
      check("timeout_not_late", 32'((err_cyc - strb_cyc) <= T_CYC + 8), 32'd1);
      check("timeout_busy", 32'(busy), 32'd0);
      link_frame = 1'b0;
      cyc_wait(10);
      wait_drain();

      // reset while a byte sits in the holding register mid-frame
      rdy_mode = 2;
      m_ready  = 1'b0;
      link_frame = 1'b1;
      cyc_wait(4);
      send_byte(8'd4);
      send_byte(8'h77);
      cyc_wait(3);
      check("pre_reset_valid", 32'(m_valid), 32'd1);
      check("pre_reset_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      link_frame = 1'b0;
      link_strb  = 1'b0;
      cyc_wait(3);
      rst_n = 1'b1;
      rdy_mode = 0;
      cyc_wait(5);

      // link still usable after the reset
      pl.delete(); pl.push_back(8'h3C); pl.push_back(8'hC3);
      run_frame(2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
